// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding for the down-timer family.
//   state_t : IDLE (accepting a load) / RUN (counting down)
package timer_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/param_down_timer.sv
// param_down_timer: loadable down-counter with one-shot/auto-reload modes and a terminal-count pulse.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_valid   : load request, qualifies load_value/auto_reload; load_ready high in IDLE only
//   load_value   : start/reload value N; auto_reload selects periodic (1) or one-shot (0)
//   enable, stop : count enable (0 freezes), abort back to IDLE without a pulse
//   count        : remaining count; underflow: one-cycle terminal pulse; busy: in RUN
module param_down_timer
    import timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [CNT_W-1:0] load_value,
    input  logic             auto_reload,
    input  logic             enable,
    input  logic             stop,
    output logic [CNT_W-1:0] count,
    output logic             underflow,
    output logic             busy
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             underflow_q, underflow_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            mode_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            mode_q      <= mode_d;
            underflow_q <= underflow_d;
        end
    end

    // RUN priority: stop beats enable=0 beats terminal beats decrement.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        mode_d      = mode_q;
        underflow_d = 1'b0;
        if (state_q == IDLE) begin
            count_d = '0;
            if (load_valid) begin
                count_d  = load_value;
                reload_d = load_value;
                mode_d   = auto_reload;
                state_d  = RUN;
            end
        end else if (stop) begin
            count_d = '0;
            state_d = IDLE;
        end else if (enable) begin
            if (count_q == '0) begin
                underflow_d = 1'b1;
                count_d     = mode_q ? reload_q : '0;
                state_d     = mode_q ? RUN : IDLE;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign count      = count_q;
    assign underflow  = underflow_q;
endmodule

// File: tb/tb_param_down_timer.sv
// tb_param_down_timer: randomized + directed scoreboard bench for param_down_timer.
module tb_param_down_timer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_value = '0;
    logic         auto_reload = 1'b0;
    logic         enable = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] count;
    logic         underflow;
    logic         busy;

    param_down_timer #(.CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_value(load_value), .auto_reload(auto_reload), .enable(enable), .stop(stop),
        .count(count), .underflow(underflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected {count, underflow, busy, load_ready} after each rising edge.
    logic [W+2:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: elapsed enabled cycles since load; period is N+1.
    bit     m_run = 0;
    bit     m_auto = 0;
    longint m_n = 0;
    longint m_e = 0;

    function automatic logic [W+2:0] model_out(bit uf);
        longint c;
        c = m_run ? m_n - (m_e % (m_n + 1)) : 0;
        return {W'(c), uf, m_run, !m_run};
    endfunction

    task automatic cyc(input bit lv, input int lval, input bit ar, input bit en, input bit st);
        bit uf;
        @(negedge clk);
        rst_n = 1'b1; load_valid = lv; load_value = W'(lval); auto_reload = ar; enable = en; stop = st;
        uf = 0;
        if (!m_run) begin
            if (lv) begin m_run = 1; m_n = lval; m_auto = ar; m_e = 0; end
        end else if (st) m_run = 0;
        else if (en) begin
            if (m_e % (m_n + 1) == m_n) begin
                uf = 1;
                if (!m_auto) m_run = 0;
            end
            m_e++;
        end
        exp_q.push_back(model_out(uf));
    endtask

    task automatic reset_cycles(input int n, input bit check_now);
        @(negedge clk);
        rst_n = 1'b0; load_valid = 0; enable = 0; stop = 0;
        m_run = 0; m_e = 0;
        if (check_now) begin
            #1;
            checks++;
            if ({count, underflow, busy, load_ready} !== {W'(0), 3'b001}) begin
                errors++;
                $display("FAIL async_reset got=%h want=%h", {count, underflow, busy, load_ready}, {W'(0), 3'b001});
            end
        end
        exp_q.push_back(model_out(0));
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            exp_q.push_back(model_out(0));
        end
    endtask

    initial begin : monitor
        logic [W+2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({count, underflow, busy, load_ready} !== e)
                    begin
                        errors++;
                        $display("FAIL scoreboard t=%0t got count=%h uf=%b busy=%b rdy=%b want count=%h uf=%b busy=%b rdy=%b",
                                 $time, count, underflow, busy, load_ready, e[W+2:3], e[2], e[1], e[0]);
                    end
            end
        end
    end

    initial begin
        reset_cycles(2, 0);
        cyc(0, 0, 0, 0, 0);
        // one-shot N=3
        cyc(1, 3, 0, 1, 0);
        repeat (6) cyc(0, 0, 0, 1, 0);
        // auto N=2, nine enabled cycles, then stop
        cyc(1, 2, 1, 1, 0);
        repeat (9) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        // auto N=4 with enable toggling, loads during RUN ignored
        cyc(1, 4, 1, 0, 0);
        for (int i = 0; i < 24; i++) cyc(i % 3 == 0, 7, 0, i % 2 == 0, 0);
        cyc(0, 0, 0, 0, 1);
        // stop collides with terminal
        cyc(1, 1, 0, 1, 0);
        cyc(1, 9, 1, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        // N=0 auto: pulse every enabled cycle
        cyc(1, 0, 1, 1, 0);
        repeat (5) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        // reset mid-run at count=5
        cyc(1, 10, 1, 1, 0);
        repeat (5) cyc(0, 0, 0, 1, 0);
        reset_cycles(2, 1);
        cyc(0, 0, 0, 0, 0);
        // N=FFFF one-shot
        cyc(1, 'hFFFF, 0, 1, 0);
        repeat (65538) cyc(0, 0, 0, 1, 0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 1), $urandom_range(0, 6), $urandom_range(0, 1),
                ($urandom % 4) != 0, ($urandom % 16) == 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
